// File: rtl/msu_host_driver.sv
// Host-side driver for the modular-squaring unit: serializes one job onto the unit's inbound
// stream, pulses ap_start, and gathers the outbound stream into a parallel result.
// Optional MSU_DRV_CYCLE_COUNT_EN adds an ap_start-to-last-result-word latency counter.
module msu_host_driver #(
    parameter int AXI_LEN     = 32,
    parameter int T_LEN       = 64,
    parameter int SQ_IN_BITS  = 1024,
    parameter int SQ_OUT_BITS = 1056
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [T_LEN-1:0]       job_t_start,
    input  logic [T_LEN-1:0]       job_t_final,
    input  logic [SQ_IN_BITS-1:0]  job_sq_in,
    output logic                   ap_start,
    input  logic                   ap_done,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXI_LEN-1:0]     m_axis_tdata,
    output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [AXI_LEN-1:0]     s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [T_LEN-1:0]       res_t_current,
    output logic [SQ_OUT_BITS-1:0] res_sq_out,
    output logic                   res_err,
    output logic [31:0]            res_cycles
);

    localparam int IN_BITS   = 2*T_LEN + SQ_IN_BITS;
    localparam int OUT_BITS  = T_LEN + SQ_OUT_BITS;
    localparam int IN_WORDS  = IN_BITS / AXI_LEN;
    localparam int OUT_WORDS = OUT_BITS / AXI_LEN;
    localparam int MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    localparam logic [CW-1:0] IN_LAST  = CW'(IN_WORDS - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_WORDS - 1);
    localparam logic [CW-1:0] OUT_FULL = CW'(OUT_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        RECV,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                sending;
    logic                done_seen;
    logic [IN_BITS-1:0]  job_sr;
    logic [OUT_BITS-1:0] res_sr;
    logic                s_fire;

    // The unit samples on tvalid alone, so tvalid must never run ahead of tready.
    assign m_axis_tvalid = sending & m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid & (cnt == IN_LAST);
    assign m_axis_tdata  = job_sr[AXI_LEN-1:0];
    assign m_axis_tkeep  = '1;
    assign s_fire        = s_axis_tvalid & s_axis_tready;

    assign res_t_current = res_sr[T_LEN-1:0];
    assign res_sq_out    = res_sr[OUT_BITS-1:T_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            job_ready     <= 1'b1;
            ap_start      <= 1'b0;
            sending       <= 1'b0;
            s_axis_tready <= 1'b0;
            res_valid     <= 1'b0;
            res_err       <= 1'b0;
            done_seen     <= 1'b0;
        end else begin
            if (state != IDLE && ap_done)
                done_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        job_ready <= 1'b0;
                        ap_start  <= 1'b1;
                        cnt       <= '0;
                        res_err   <= 1'b0;
                        done_seen <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    ap_start <= 1'b0;
                    sending  <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (m_axis_tvalid) begin
                        if (cnt == IN_LAST) begin
                            sending       <= 1'b0;
                            s_axis_tready <= 1'b1;
                            cnt           <= '0;
                            state         <= RECV;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (s_fire) begin
                        if (s_axis_tlast) begin
                            s_axis_tready <= 1'b0;
                            state         <= WAIT_DONE;
                            if (cnt != OUT_LAST)
                                res_err <= 1'b1;
                        end else if (cnt != OUT_FULL) begin
                            // A full frame without tlast is an error; the counter parks at
                            // OUT_FULL so the remaining words are dropped until tlast.
                            cnt <= cnt + 1'b1;
                            if (cnt == OUT_LAST)
                                res_err <= 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (done_seen || ap_done) begin
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload registers carry no reset; they are only meaningful alongside the handshakes.
    always_ff @(posedge clk) begin
        if (state == IDLE && job_valid)
            job_sr <= {job_sq_in, job_t_final, job_t_start};
        else if (m_axis_tvalid)
            job_sr <= {{AXI_LEN{1'b0}}, job_sr[IN_BITS-1:AXI_LEN]};

        if (state == RECV && s_fire && cnt != OUT_FULL)
            res_sr <= {s_axis_tdata, res_sr[OUT_BITS-1:AXI_LEN]};
    end

`ifdef MSU_DRV_CYCLE_COUNT_EN
    logic [31:0] cycles;

    always_ff @(posedge clk) begin
        if (reset)
            cycles <= '0;
        else if (state == START)
            cycles <= '0;
        else if ((state == SEND || state == RECV) && cycles != 32'hFFFF_FFFF)
            cycles <= cycles + 32'd1;
    end

    assign res_cycles = cycles;
`else
    assign res_cycles = '0;
`endif

endmodule
